// File: rtl/led_sweep_ctrl.sv
// led_sweep_ctrl: 8-LED pattern sequencer (sweep, chase, fill, blink) with mode/speed buttons and a pause switch.
// Optional feature: define LED_DEBOUNCE_EN to insert a per-button debouncer after the synchronizers.
module led_sweep_ctrl #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned BASE_PERIOD     = 2**23,
  parameter int unsigned DEBOUNCE_CYCLES = 2**20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_speed,
  input  logic       sw_pause,
  output logic [7:0] leds,
  output logic [1:0] mode,
  output logic [1:0] speed,
  output logic       step
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LOAD} state_t;

  state_t           state_q;
  logic [7:0]       leds_q;
  logic [1:0]       mode_q;
  logic [1:0]       speed_q;
  logic             step_q;
  logic             dir_left_q;
  logic [WIDTH-1:0] presc_q;

  logic [1:0]       btn_s1_q;
  logic [1:0]       btn_s2_q;
  logic             pause_s1_q;
  logic             pause_s2_q;
  logic [1:0]       sync_vld_q;
  logic [1:0]       press;

  logic [WIDTH-1:0] period_d;
  logic             wrap_d;
  logic [7:0]       leds_step_d;
  logic             dir_step_d;
  logic [1:0]       mode_next_d;
  logic [7:0]       leds_init_d;

`ifdef LED_DEBOUNCE_EN
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
`else
  logic unused_db_cfg;
  assign unused_db_cfg = (DEBOUNCE_CYCLES != 0);
`endif

  // Bit 0 carries the mode button, bit 1 the speed button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      pause_s1_q <= 1'b0;
      pause_s2_q <= 1'b0;
      sync_vld_q <= '0;
    end else begin
      btn_s1_q   <= {btn_speed, btn_mode};
      btn_s2_q   <= btn_s1_q;
      pause_s1_q <= sw_pause;
      pause_s2_q <= pause_s1_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic lvl;
    logic prev_q;
    logic armed_q;
    logic press_q;

`ifdef LED_DEBOUNCE_EN
    logic [DB_W-1:0] db_cnt_q;
    logic            db_lvl_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_cnt_q <= '0;
        db_lvl_q <= 1'b0;
      end else if (btn_s2_q[gi] != db_lvl_q) begin
        if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_lvl_q <= btn_s2_q[gi];
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DB_W'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end

    assign lvl = db_lvl_q;
`else
    assign lvl = btn_s2_q[gi];
`endif

    // A button held through reset must be seen released before it can produce a press.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prev_q  <= 1'b0;
        armed_q <= 1'b0;
        press_q <= 1'b0;
      end else begin
        prev_q  <= lvl;
        armed_q <= armed_q | (sync_vld_q[1] & ~btn_s2_q[gi]);
        press_q <= lvl & ~prev_q & armed_q;
      end
    end

    assign press[gi] = press_q;
  end

  assign period_d    = WIDTH'(BASE_PERIOD) >> speed_q;
  assign wrap_d      = (presc_q == period_d - WIDTH'(1));
  assign mode_next_d = mode_q + 2'd1;
  assign leds_init_d = (mode_next_d == 2'd3) ? 8'h55 : 8'h01;

  always_comb begin
    leds_step_d = leds_q;
    dir_step_d  = dir_left_q;
    unique case (mode_q)
      2'd0: begin
        if (dir_left_q) begin
          if (leds_q == 8'h80) begin
            leds_step_d = 8'h40;
            dir_step_d  = 1'b0;
          end else begin
            leds_step_d = leds_q << 1;
          end
        end else begin
          if (leds_q == 8'h01) begin
            leds_step_d = 8'h02;
            dir_step_d  = 1'b1;
          end else begin
            leds_step_d = leds_q >> 1;
          end
        end
      end
      2'd1:    leds_step_d = {leds_q[6:0], leds_q[7]};
      2'd2:    leds_step_d = (leds_q == 8'hFF) ? 8'h00 : {leds_q[6:0], 1'b1};
      default: leds_step_d = (leds_q == 8'h55) ? 8'hAA : 8'h55;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      leds_q     <= 8'h01;
      mode_q     <= 2'd0;
      speed_q    <= 2'd0;
      step_q     <= 1'b0;
      dir_left_q <= 1'b1;
      presc_q    <= '0;
    end else begin
      step_q <= 1'b0;
      if (press[1] && state_q != IDLE) begin
        speed_q <= speed_q + 2'd1;
      end
      unique case (state_q)
        IDLE: begin
          presc_q <= '0;
          state_q <= RUN;
        end
        RUN: begin
          if (press[0]) begin
            state_q    <= LOAD;
            mode_q     <= mode_next_d;
            leds_q     <= leds_init_d;
            dir_left_q <= 1'b1;
            presc_q    <= '0;
          end else begin
            // The counter keeps running in the last RUN cycle before PAUSE, so a coincident wrap still steps.
            if (press[1]) begin
              presc_q <= '0;
            end else if (wrap_d) begin
              presc_q    <= '0;
              leds_q     <= leds_step_d;
              dir_left_q <= dir_step_d;
              step_q     <= 1'b1;
            end else begin
              presc_q <= presc_q + WIDTH'(1);
            end
            if (pause_s2_q) begin
              state_q <= PAUSE;
            end
          end
        end
        PAUSE: begin
          if (press[0]) begin
            state_q    <= LOAD;
            mode_q     <= mode_next_d;
            leds_q     <= leds_init_d;
            dir_left_q <= 1'b1;
            presc_q    <= '0;
          end else begin
            if (press[1]) begin
              presc_q <= '0;
            end
            if (!pause_s2_q) begin
              state_q <= RUN;
            end
          end
        end
        LOAD: begin
          presc_q <= '0;
          state_q <= RUN;
        end
      endcase
    end
  end

  assign leds  = leds_q;
  assign mode  = mode_q;
  assign speed = speed_q;
  assign step  = step_q;

endmodule
